whack_detector: RTL and testbench



---
 rtl/whack_pkg.sv | 25 ++
 rtl/whack_detector_switch_debouncer.sv | 76 +++++++
 rtl/whack_detector.sv | 141 ++++++++++++++
 tb/tb_whack_detector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared constants, event encoding and saturating counter helpers for the
// whack detector.
package whack_pkg;

  localparam int N_HOLES = 18;
  localparam int SCORE_W = 14;
  localparam int COMBO_W = 7;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;
  localparam logic [COMBO_W-1:0] COMBO_MAX = 7'd99;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_HIT  = 2'd1,
    EV_MISS = 2'd2
  } whack_ev_t;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [COMBO_W-1:0] combo_inc(input logic [COMBO_W-1:0] v);
    return (v >= COMBO_MAX) ? v : v + COMBO_W'(1);
  endfunction

endpackage

// File: rtl/whack_detector_switch_debouncer.sv
// Switch front end: 2-FF synchroniser, ms/debounce tick counters and a
// two-sample agreement filter producing the clean switch levels.
module switch_debouncer #(
  parameter int CLKS_PER_MS = 50000,
  parameter int DEBOUNCE_MS = 10,
  parameter int N_HOLES     = whack_pkg::N_HOLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] sw_clean
);

  localparam int MS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic [N_HOLES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_HOLES-1:0] sample_q, sample_d, clean_q, clean_d, same_s;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               ms_tick_s, db_tick_s;

  // Tick generation and the per-bit sample/compare update
  always_comb begin
    sync1_d   = sw;
    sync2_d   = sync1_q;
    ms_tick_s = (ms_cnt_q == MS_W'(CLKS_PER_MS - 1));
    db_tick_s = ms_tick_s && (db_cnt_q == DB_W'(DEBOUNCE_MS - 1));
    same_s    = ~(sync2_q ^ sample_q);

    if (ms_tick_s) begin
      ms_cnt_d = '0;
    end else begin
      ms_cnt_d = ms_cnt_q + MS_W'(1);
    end

    if (db_tick_s) begin
      db_cnt_d = '0;
    end else if (ms_tick_s) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end else begin
      db_cnt_d = db_cnt_q;
    end

    // A bit only moves once two consecutive debounce samples agree
    if (db_tick_s) begin
      sample_d = sync2_q;
      clean_d  = (sync2_q & same_s) | (clean_q & ~same_s);
    end else begin
      sample_d = sample_q;
      clean_d  = clean_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      clean_q  <= '0;
      ms_cnt_q <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sample_q <= sample_d;
      clean_q  <= clean_d;
      ms_cnt_q <= ms_cnt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign sw_clean = clean_q;

endmodule

// File: rtl/whack_detector.sv
// Turns debounced switch toggles into hit/miss events against the live mole
// mask, one event per cycle, and keeps the score and combo counters.
module whack_detector #(
  parameter int CLKS_PER_MS = 50000,
  parameter int DEBOUNCE_MS = 10,
  parameter int N_HOLES     = whack_pkg::N_HOLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_HOLES-1:0]            sw,
  input  logic [N_HOLES-1:0]            mole_positions,
  input  logic                          mole_up_window,
  input  logic                          game_active,
  output logic [N_HOLES-1:0]            sw_clean,
  output logic                          hit_pulse,
  output logic                          miss_pulse,
  output logic [N_HOLES-1:0]            whacked_mask,
  output logic [whack_pkg::SCORE_W-1:0] score,
  output logic [whack_pkg::COMBO_W-1:0] combo_count
);

  import whack_pkg::*;

  localparam logic [N_HOLES-1:0] ONE_LSB = {{(N_HOLES-1){1'b0}}, 1'b1};

  logic [N_HOLES-1:0] sw_clean_s, toggle_s, served_s;
  logic [N_HOLES-1:0] clean_prev_q, clean_prev_d, pending_q, pending_d;
  logic [N_HOLES-1:0] mole_q, mole_d, whacked_q, whacked_d;
  logic               win_q, win_d, active_q, active_d;
  logic               hit_q, hit_d, miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               flush_s, start_s, live_s, fresh_s;
  whack_ev_t          ev_s;

  switch_debouncer #(
    .CLKS_PER_MS (CLKS_PER_MS),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .N_HOLES     (N_HOLES)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_clean (sw_clean_s)
  );

  // Toggle detect, lowest-index priority pick and event classification
  always_comb begin
    toggle_s = sw_clean_s ^ clean_prev_q;
    served_s = pending_q & (~pending_q + ONE_LSB);
    flush_s  = (mole_positions != mole_q) || (win_q && !mole_up_window);
    start_s  = game_active && !active_q;
    live_s   = game_active && mole_up_window;
    fresh_s  = |(served_s & mole_positions & ~whacked_q);

    // A flush or a game start pre-empts serving in that cycle
    if (flush_s || start_s || !(|served_s)) begin
      ev_s = EV_NONE;
    end else if (!live_s) begin
      ev_s = EV_NONE;
    end else if (fresh_s) begin
      ev_s = EV_HIT;
    end else begin
      ev_s = EV_MISS;
    end
  end

  // Next-state for queue, mask, counters and strobes
  always_comb begin
    clean_prev_d = sw_clean_s;
    mole_d       = mole_positions;
    win_d        = mole_up_window;
    active_d     = game_active;
    hit_d        = (ev_s == EV_HIT);
    miss_d       = (ev_s == EV_MISS);
    whacked_d    = whacked_q;
    score_d      = score_q;
    combo_d      = combo_q;

    case (ev_s)
      EV_HIT: begin
        whacked_d = whacked_q | served_s;
        score_d   = score_inc(score_q);
        combo_d   = combo_inc(combo_q);
      end
      EV_MISS: begin
        combo_d = '0;
      end
      default: begin
        combo_d = combo_q;
      end
    endcase

    if (start_s) begin
      pending_d = '0;
      whacked_d = '0;
      score_d   = '0;
      combo_d   = '0;
    end else if (flush_s) begin
      pending_d = '0;
      whacked_d = '0;
    end else begin
      pending_d = (pending_q & ~served_s) | toggle_s;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean_prev_q <= '0;
      pending_q    <= '0;
      mole_q       <= '0;
      whacked_q    <= '0;
      win_q        <= 1'b0;
      active_q     <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      score_q      <= '0;
      combo_q      <= '0;
    end else begin
      clean_prev_q <= clean_prev_d;
      pending_q    <= pending_d;
      mole_q       <= mole_d;
      whacked_q    <= whacked_d;
      win_q        <= win_d;
      active_q     <= active_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
    end
  end

  assign sw_clean     = sw_clean_s;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign whacked_mask = whacked_q;
  assign score        = score_q;
  assign combo_count  = combo_q;

endmodule

// File: tb/tb_whack_detector.sv
// Scoreboard bench for whack_detector: stimulus pushes expected events, a
// negedge monitor pops and compares them whenever a pulse appears.
module tb_whack_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] sw = 18'd0;
  logic [17:0] mole_positions = 18'd0;
  logic        mole_up_window = 1'b0;
  logic        game_active = 1'b0;
  logic [17:0] sw_clean, whacked_mask;
  logic        hit_pulse, miss_pulse;
  logic [13:0] score;
  logic [6:0]  combo_count;

  typedef struct {
    bit          is_hit;
    int          score;
    int          combo;
    logic [17:0] mask;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          m_score = 0;
  int          m_combo = 0;
  logic [17:0] m_mask = 18'd0;

  whack_detector #(
    .CLKS_PER_MS (5),
    .DEBOUNCE_MS (2),
    .N_HOLES     (18)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw             (sw),
    .mole_positions (mole_positions),
    .mole_up_window (mole_up_window),
    .game_active    (game_active),
    .sw_clean       (sw_clean),
    .hit_pulse      (hit_pulse),
    .miss_pulse     (miss_pulse),
    .whacked_mask   (whacked_mask),
    .score          (score),
    .combo_count    (combo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      check("pulse_exclusive", 32'(hit_pulse & miss_pulse), 32'd0);
      if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: hit=%b miss=%b at cycle %0d, expected no pulse",
                   hit_pulse, miss_pulse, cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", 32'({hit_pulse, miss_pulse}), e.is_hit ? 32'd2 : 32'd1);
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          check("pulse_score", 32'(score), 32'(e.score));
          check("pulse_combo", 32'(combo_count), 32'(e.combo));
          check("pulse_mask", 32'(whacked_mask), 32'(e.mask));
        end
      end
    end
  end

  // Reference model: serve toggled bits lowest first, one per cycle from t+2
  task automatic expect_toggles(input logic [17:0] bits, input int t);
    int   k;
    exp_t e;
    k = 0;
    for (int i = 0; i < 18; i++) begin
      if (bits[i]) begin
        if (game_active && mole_up_window) begin
          if (mole_positions[i] && !m_mask[i]) begin
            m_score   = (m_score >= 9999) ? 9999 : m_score + 1;
            m_combo   = (m_combo >= 99) ? 99 : m_combo + 1;
            m_mask[i] = 1'b1;
            e.is_hit  = 1'b1;
          end else begin
            m_combo  = 0;
            e.is_hit = 1'b0;
          end
          e.score = m_score;
          e.combo = m_combo;
          e.mask  = m_mask;
          e.cyc   = t + 2 + k;
          sb.push_back(e);
        end
        k++;
      end
    end
  endtask

  // Flip switches, wait for sw_clean to follow, optionally queue expectations
  task automatic toggle_sw(input logic [17:0] bits, input bit model);
    logic [17:0] target;
    bit          ok;
    ok     = 1'b0;
    sw     = sw ^ bits;
    target = sw;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sw_clean === target) ok = 1'b1;
    end
    check("sw_clean_follow", 32'(ok), 32'd1);
    if (ok && model) expect_toggles(bits, cyc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_moles(input logic [17:0] m);
    mole_positions = m;
    m_mask         = 18'd0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    bit seen;
    // 1. Reset with random switches
    sw = 18'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("reset_sw_clean", 32'(sw_clean), 32'd0);
      check("reset_whacked", 32'(whacked_mask), 32'd0);
      check("reset_score", 32'(score), 32'd0);
      check("reset_combo", 32'(combo_count), 32'd0);
      check("reset_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
      sw = 18'($urandom);
    end
    sw    = 18'd0;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_sw_clean", 32'(sw_clean), 32'd0);

    // 2. Single hit then miss on an already-whacked mole
    game_active    = 1'b1;
    mole_up_window = 1'b1;
    set_moles(18'h00010);
    toggle_sw(18'h00010, 1'b1);
    wait_drain();
    check("hit_score", 32'(score), 32'd1);
    check("hit_mask", 32'(whacked_mask), 32'h00010);
    toggle_sw(18'h00010, 1'b1);
    wait_drain();
    check("miss_combo", 32'(combo_count), 32'd0);
    check("miss_score", 32'(score), 32'd1);

    // 3. Simultaneous toggles on holes 5 and 14
    set_moles(18'h04020);
    check("set_change_mask", 32'(whacked_mask), 32'd0);
    toggle_sw(18'h04020, 1'b1);
    wait_drain();
    check("dual_score", 32'(score), 32'd3);
    check("dual_combo", 32'(combo_count), 32'd2);
    check("dual_mask", 32'(whacked_mask), 32'h04020);

    // 4. Three-clock glitch on switch 9
    seen  = 1'b0;
    sw[9] = 1'b1;
    repeat (3) @(negedge clk);
    sw[9] = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (sw_clean[9] !== 1'b0) seen = 1'b1;
    end
    check("bounce_clean", 32'(seen), 32'd0);

    // 5a. Window falls (flush), then a toggle outside the window
    mole_up_window = 1'b0;
    m_mask         = 18'd0;
    repeat (3) @(negedge clk);
    check("window_fall_mask", 32'(whacked_mask), 32'd0);
    toggle_sw(18'h00020, 1'b1);
    repeat (10) @(negedge clk);
    check("no_window_score", 32'(score), 32'd3);

    // 5b. Three events pending when the mole set changes
    mole_up_window = 1'b1;
    set_moles(18'h0004E);
    toggle_sw(18'h00040, 1'b1);
    wait_drain();
    check("pre_flush_mask", 32'(whacked_mask), 32'h00040);
    toggle_sw(18'h0000E, 1'b0);
    @(negedge clk);
    check("pending_mask_held", 32'(whacked_mask), 32'h00040);
    mole_positions = 18'h00080;
    m_mask         = 18'd0;
    @(negedge clk);
    check("flush_mask", 32'(whacked_mask), 32'd0);
    repeat (10) @(negedge clk);
    check("flush_score", 32'(score), 32'd4);
    check("flush_combo", 32'(combo_count), 32'd3);

    // 6. 108 consecutive hits: combo saturates at 99
    set_moles(18'h3FFFF);
    for (int r = 0; r < 6; r++) begin
      toggle_sw(18'h3FFFF, 1'b1);
      wait_drain();
      mole_positions = 18'd0;
      @(negedge clk);
      set_moles(18'h3FFFF);
    end
    check("sat_combo", 32'(combo_count), 32'd99);
    check("sat_score", 32'(score), 32'd112);

    // Game restart clears score and combo on the next edge
    game_active = 1'b0;
    repeat (3) @(negedge clk);
    game_active = 1'b1;
    m_score     = 0;
    m_combo     = 0;
    m_mask      = 18'd0;
    @(negedge clk);
    check("restart_score", 32'(score), 32'd0);
    check("restart_combo", 32'(combo_count), 32'd0);
    check("restart_mask", 32'(whacked_mask), 32'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
